// File: rtl/if_fetch_pkg.sv
// Shared constants and small helpers for the instruction-fetch stage.
package if_fetch_pkg;

  localparam logic        rom_enable   = 1'b1;
  localparam logic        rom_disable  = 1'b0;
  localparam logic [31:0] zero_word    = 32'h0000_0000;
  localparam logic [31:0] reset_pc_def = 32'h0000_0000;
  localparam logic [31:0] nop_inst_def = 32'h0000_0000;
  localparam int          stall_w      = 2;

  typedef logic [stall_w-1:0] stall_bus_t;

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_if_id_reg.sv
// IF/ID pipeline register with flush, bubble and hold handling.
module if_id_reg
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INST = nop_inst_def
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rom_ce,
  input  logic        flush,
  input  stall_bus_t  stall,
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_adel
);

  // A downstream stall without an upstream one (2'b10) behaves as a full stall.
  logic hold;
  logic bubble;

  assign hold   = stall[1];
  assign bubble = stall[0] & ~stall[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_pc   <= zero_word;
      id_inst <= NOP_INST;
      id_adel <= 1'b0;
    end else if (flush || bubble || (!hold && rom_ce == rom_disable)) begin
      id_pc   <= zero_word;
      id_inst <= NOP_INST;
      id_adel <= 1'b0;
    end else if (!hold) begin
      id_pc   <= pc;
      id_inst <= inst;
      id_adel <= misaligned(pc);
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the ROM and feeds IF/ID.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = reset_pc_def,
  parameter logic [31:0] NOP_INST = nop_inst_def
) (
  input  logic        clk,
  input  logic        rst_n,
  input  stall_bus_t  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_adel
);

  logic [31:0] pc;
  logic        pc_hold;

  assign pc_hold  = |stall;
  assign rom_addr = pc;

  // The PC only moves once the ROM was enabled on the previous edge,
  // so the first fetch is always RESET_PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      rom_ce <= rom_disable;
    end else begin
      rom_ce <= rom_enable;
      if (rom_ce == rom_enable) begin
        if (flush)
          pc <= new_pc;
        else if (pc_hold)
          pc <= pc;
        else if (branch_flag)
          pc <= branch_target;
        else
          pc <= seq_pc(pc);
      end
    end
  end

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .rom_ce  (rom_ce),
    .flush   (flush),
    .stall   (stall),
    .pc      (pc),
    .inst    (rom_data),
    .id_pc   (id_pc),
    .id_inst (id_inst),
    .id_adel (id_adel)
  );

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a combinational ROM model.
module tb_if_fetch;

  logic        clk;
  logic        rst_n;
  logic [1:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_adel;

  int passed = 0;
  int total  = 0;

  if_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .rom_ce        (rom_ce),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .id_pc         (id_pc),
    .id_inst       (id_inst),
    .id_adel       (id_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word 0 holds 32'h34010000; other words encode their aligned address.
  always_comb begin
    if (rom_addr[31:2] == 30'd0)
      rom_data = 32'h3401_0000;
    else
      rom_data = {8'hA5, rom_addr[23:2], 2'b00};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 2'b00; flush = 1'b0; new_pc = 32'h0;
    branch_flag = 1'b0; branch_target = 32'h0;
    tick(); tick(); tick();
    total++; if (rom_ce !== 1'b0) $display("FAIL reset_ce: got %b want 0", rom_ce); else passed++;
    total++; if (id_inst !== 32'h0) $display("FAIL reset_inst: got %h want 00000000", id_inst); else passed++;
    rst_n = 1'b1;
    tick();
    total++; if (rom_ce !== 1'b1) $display("FAIL start_ce: got %b want 1", rom_ce); else passed++;
    total++; if (rom_addr !== 32'h0) $display("FAIL start_addr: got %h want 00000000", rom_addr); else passed++;
    total++; if (id_inst !== 32'h0) $display("FAIL start_nop: got %h want 00000000", id_inst); else passed++;
    tick();
    total++; if (rom_addr !== 32'h4) $display("FAIL start_addr4: got %h want 00000004", rom_addr); else passed++;
    total++; if (id_inst !== 32'h3401_0000) $display("FAIL first_inst: got %h want 34010000", id_inst); else passed++;
    total++; if (id_pc !== 32'h0) $display("FAIL first_pc: got %h want 00000000", id_pc); else passed++;
    tick();
    total++; if (rom_addr !== 32'h8) $display("FAIL start_addr8: got %h want 00000008", rom_addr); else passed++;
    total++; if (id_pc !== 32'h4) $display("FAIL second_pc: got %h want 00000004", id_pc); else passed++;
  endtask

  task automatic test_full_stall();
    stall = 2'b11;
    tick(); tick();
    total++; if (rom_addr !== 32'h8) $display("FAIL stall_addr: got %h want 00000008", rom_addr); else passed++;
    total++; if (id_pc !== 32'h4) $display("FAIL stall_id_pc: got %h want 00000004", id_pc); else passed++;
    total++; if (id_inst !== 32'hA500_0004) $display("FAIL stall_id_inst: got %h want a5000004", id_inst); else passed++;
    stall = 2'b00;
    tick();
    total++; if (rom_addr !== 32'hC) $display("FAIL stall_release: got %h want 0000000c", rom_addr); else passed++;
    total++; if (id_pc !== 32'h8) $display("FAIL stall_release_pc: got %h want 00000008", id_pc); else passed++;
  endtask

  task automatic test_bubble();
    tick();
    total++; if (rom_addr !== 32'h10) $display("FAIL bubble_pre: got %h want 00000010", rom_addr); else passed++;
    stall = 2'b01;
    tick();
    total++; if (rom_addr !== 32'h10) $display("FAIL bubble_hold: got %h want 00000010", rom_addr); else passed++;
    total++; if (id_inst !== 32'h0) $display("FAIL bubble_inst: got %h want 00000000", id_inst); else passed++;
    total++; if (id_pc !== 32'h0) $display("FAIL bubble_pc: got %h want 00000000", id_pc); else passed++;
    stall = 2'b00;
    tick();
    total++; if (id_pc !== 32'h10) $display("FAIL bubble_after: got %h want 00000010", id_pc); else passed++;
    total++; if (id_inst !== 32'hA500_0010) $display("FAIL bubble_after_inst: got %h want a5000010", id_inst); else passed++;
  endtask

  task automatic test_branch();
    branch_flag = 1'b1; branch_target = 32'h50;
    tick();
    total++; if (rom_addr !== 32'h50) $display("FAIL branch_addr: got %h want 00000050", rom_addr); else passed++;
    total++; if (id_pc !== 32'h14) $display("FAIL delay_slot: got %h want 00000014", id_pc); else passed++;
    branch_flag = 1'b0;
    tick();
    total++; if (rom_addr !== 32'h54) $display("FAIL branch_seq: got %h want 00000054", rom_addr); else passed++;
    // Branch during a stall is dropped.
    stall = 2'b11; branch_flag = 1'b1; branch_target = 32'h90;
    tick();
    total++; if (rom_addr !== 32'h54) $display("FAIL stalled_branch: got %h want 00000054", rom_addr); else passed++;
    stall = 2'b00; branch_flag = 1'b0;
    tick();
    total++; if (rom_addr !== 32'h58) $display("FAIL stalled_branch_seq: got %h want 00000058", rom_addr); else passed++;
    total++; if (id_pc !== 32'h54) $display("FAIL stalled_branch_id: got %h want 00000054", id_pc); else passed++;
  endtask

  task automatic test_flush_priority();
    flush = 1'b1; new_pc = 32'h40; branch_flag = 1'b1; branch_target = 32'h80; stall = 2'b11;
    tick();
    total++; if (rom_addr !== 32'h40) $display("FAIL flush_addr: got %h want 00000040", rom_addr); else passed++;
    total++; if (id_inst !== 32'h0) $display("FAIL flush_inst: got %h want 00000000", id_inst); else passed++;
    total++; if (id_adel !== 1'b0) $display("FAIL flush_adel: got %b want 0", id_adel); else passed++;
    flush = 1'b0; branch_flag = 1'b0; stall = 2'b00;
    tick();
    total++; if (rom_addr !== 32'h44) $display("FAIL flush_seq: got %h want 00000044", rom_addr); else passed++;
    total++; if (id_pc !== 32'h40) $display("FAIL flush_seq_id: got %h want 00000040", id_pc); else passed++;
  endtask

  task automatic test_wrap_misalign();
    flush = 1'b1; new_pc = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0;
    total++; if (rom_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_load: got %h want fffffffc", rom_addr); else passed++;
    tick();
    total++; if (rom_addr !== 32'h0) $display("FAIL wrap_pc: got %h want 00000000", rom_addr); else passed++;
    total++; if (id_inst !== 32'hA5FF_FFFC) $display("FAIL wrap_inst: got %h want a5fffffc", id_inst); else passed++;
    branch_flag = 1'b1; branch_target = 32'h52;
    tick();
    branch_flag = 1'b0;
    total++; if (rom_addr !== 32'h52) $display("FAIL misalign_addr: got %h want 00000052", rom_addr); else passed++;
    tick();
    total++; if (id_adel !== 1'b1) $display("FAIL misalign_adel: got %b want 1", id_adel); else passed++;
    total++; if (id_inst !== 32'hA500_0050) $display("FAIL misalign_inst: got %h want a5000050", id_inst); else passed++;
    total++; if (rom_addr !== 32'h56) $display("FAIL misalign_seq: got %h want 00000056", rom_addr); else passed++;
    tick();
    total++; if (id_pc !== 32'h56) $display("FAIL misalign_seq_id: got %h want 00000056", id_pc); else passed++;
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (rom_ce !== 1'b0) $display("FAIL async_ce: got %b want 0", rom_ce); else passed++;
    total++; if (rom_addr !== 32'h0) $display("FAIL async_addr: got %h want 00000000", rom_addr); else passed++;
    total++; if (id_pc !== 32'h0) $display("FAIL async_id_pc: got %h want 00000000", id_pc); else passed++;
    total++; if (id_adel !== 1'b0) $display("FAIL async_adel: got %b want 0", id_adel); else passed++;
  endtask

  initial begin
    test_reset();
    test_full_stall();
    test_bubble();
    test_branch();
    test_flush_priority();
    test_wrap_misalign();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage of the PowerStar MIPS core, directly upstream of the instruction ROM.
- Owns the program counter and drives the ROM's chip-enable and address.
- Captures the returned instruction word into the IF/ID pipeline register.
- Handles pipeline stalls, branch redirects and exception/eret flush redirects from the control unit.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset and used for the first fetch.
- NOP_INST, 32'h00000000, instruction word inserted into IF/ID on a bubble or flush.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  2  stall[0] freezes the PC; stall[1] freezes IF/ID.
- flush  in  1  exception/eret redirect from the control unit; highest priority.
- new_pc  in  32  redirect target used when flush=1 (exception vector or EPC).
- branch_flag  in  1  taken branch/jump resolved in ID.
- branch_target  in  32  target address used when branch_flag=1.
- rom_ce  out  1  ROM chip-enable; RomEnable/RomDisable encoding from define.v.
- rom_addr  out  32  byte fetch address, equal to the current PC.
- rom_data  in  32  instruction word from the ROM, combinational in the same cycle.
- id_pc  out  32  PC of the instruction held in IF/ID.
- id_inst  out  32  instruction held in IF/ID.
- id_adel  out  1  fetch-address-error flag travelling with id_inst.

Behaviour:
Reset:
- rst_n=0 asynchronously forces: pc=RESET_PC, rom_ce=RomDisable, id_pc=0, id_inst=NOP_INST, id_adel=0.
- Reset asserted mid-operation discards everything in flight immediately, not at the next edge.

Start-up:
- First rising edge after rst_n deasserts: rom_ce becomes RomEnable; pc stays at RESET_PC.
- The PC advances only on edges where rom_ce was already RomEnable. The first fetched address is therefore RESET_PC.
- While rom_ce=RomDisable, rom_data is ignored and IF/ID loads NOP_INST.

rom_addr is pc (combinational). The fetch-to-IF/ID latency is 1 cycle: the instruction at pc appears on id_inst after the next edge.

Next-PC selection, in strict priority order, evaluated on each edge when rom_ce is enabled:
1. flush=1: pc <= new_pc. Stall and branch inputs are ignored.
2. stall[0]=1: pc holds.
3. branch_flag=1: pc <= branch_target. The delay-slot instruction is already in IF and proceeds normally.
4. Otherwise: pc <= pc+4, 32-bit modulo. 32'hFFFFFFFC wraps to 32'h00000000 with no flag.

IF/ID register update, priority order:
- flush=1: id_inst=NOP_INST, id_pc=0, id_adel=0.
- stall[0]=1 and stall[1]=0: bubble. id_inst=NOP_INST, id_pc=0, id_adel=0.
- stall[0]=0: id_pc=pc, id_inst=rom_data, id_adel=(pc[1:0]!=0).
- stall[0]=1 and stall[1]=1: hold all three.
- stall=2'b10 is illegal (a downstream stall always implies an upstream stall). It is treated as 2'b11.

Misaligned targets:
- A misaligned branch_target or new_pc is loaded into pc unmodified.
- The ROM ignores addr[1:0]. id_adel marks the result so EX/MEM can raise AdEL.
- The next sequential PC continues as pc+4 from the misaligned value.

Simultaneous events:
- flush overrides stall and branch in the same cycle.
- branch during stall[0] is lost. The ID stage holds branch_flag asserted until the stall releases; this stage keeps no memory of a stalled branch.

Decomposition:
- Shared constants in define.v: RomEnable, RomDisable, Zero, plus new `ResetPC, `NopInst, `StallBus (2-bit width).
- One sub-module, if_id_reg: holds the IF/ID register and its flush/bubble/hold logic.
- PC register and next-PC mux stay in if_fetch.

Test Plan:
1. Reset start-up: hold rst_n=0 for 3 cycles, then release. Required: rom_ce=0 during reset; after the first edge rom_ce=1 and rom_addr=0. Following edges give rom_addr 4, 8. With ROM word 0 = 32'h34010000, id_inst=32'h34010000 and id_pc=0 one edge after the first fetch.
2. Full stall: at pc=0x8 drive stall=2'b11 for 2 cycles. Required: rom_addr holds 0x8; id_pc/id_inst hold the 0x4 instruction. After release, pc=0xC.
3. Bubble: at pc=0x10 drive stall=2'b01 for 1 cycle. Required: pc holds 0x10; id_inst=0 and id_pc=0 for that cycle; the next cycle id_pc=0x10.
4. Branch: with branch_flag=1 and branch_target=0x50 while pc=0x14. Required: the next rom_addr is 0x50; the delay slot at 0x14 reaches id_pc.
5. Flush priority: flush=1, new_pc=0x40, branch_flag=1 (target 0x80) and stall=2'b11, all in one cycle. Required: pc=0x40, id_inst=0, id_adel=0.
6. Wrap and misalignment: force pc=0xFFFFFFFC, then advance. Required: pc=0. Then branch to 0x52. Required: rom_addr=0x52, id_adel=1 on the next edge, following fetch at 0x56. Finally assert rst_n=0 mid-cycle: outputs clear before the next edge.
